// File: rtl/alu_operand_sequencer_pkg.sv
// Shared constants for the ALU operand sequencer: 8051 ALU-class opcodes,
// FSM state encoding and the decoder's classification record.
package alu_operand_sequencer_pkg;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    localparam logic [7:0] OP_ADD_IMM   = 8'h24;
    localparam logic [7:0] OP_SUBB_IMM  = 8'h94;
    localparam logic [7:0] OP_ANL_IMM   = 8'h54;
    localparam logic [7:0] OP_ORL_IMM   = 8'h44;
    localparam logic [7:0] OP_XRL_IMM   = 8'h64;
    localparam logic [7:0] OP_MOV_A_IMM = 8'h74;

    // Register forms occupy an aligned block of eight; low three bits select Rn.
    localparam logic [7:0] OP_ADD_REG   = 8'h28;
    localparam logic [7:0] OP_SUBB_REG  = 8'h98;
    localparam logic [7:0] OP_ANL_REG   = 8'h58;
    localparam logic [7:0] OP_ORL_REG   = 8'h48;
    localparam logic [7:0] OP_XRL_REG   = 8'h68;
    localparam logic [7:0] OP_MOV_A_REG = 8'hE8;
    localparam logic [7:0] OP_MOV_RN_IMM = 8'h78;

    localparam int NUM_FORMS = 6;

    localparam logic [NUM_FORMS-1:0][7:0] IMM_FORMS = {
        OP_ADD_IMM, OP_SUBB_IMM, OP_ANL_IMM, OP_ORL_IMM, OP_XRL_IMM, OP_MOV_A_IMM
    };

    localparam logic [NUM_FORMS-1:0][7:0] REG_FORM_BASES = {
        OP_ADD_REG, OP_SUBB_REG, OP_ANL_REG, OP_ORL_REG, OP_XRL_REG, OP_MOV_A_REG
    };

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_IMM = 3'd1,
        ST_READ_REG  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WRITEBACK = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic legal;
        logic needs_imm;
        logic needs_reg;
        logic wb_to_rn;
    } op_class_t;

endpackage

// File: rtl/alu_operand_sequencer_decoder.sv
// Combinational classifier: opcode -> {legal, needs_imm, needs_reg, wb_to_rn}.
module alu_opcode_decoder
    import alu_operand_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output op_class_t  op_class
);

    logic [NUM_FORMS-1:0] imm_hit;
    logic [NUM_FORMS-1:0] reg_hit;
    logic                 mov_rn_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FORMS; gi++) begin : g_form
            assign imm_hit[gi] = (opcode == IMM_FORMS[gi]);
            assign reg_hit[gi] = (opcode[7:3] == REG_FORM_BASES[gi][7:3]);
        end
    endgenerate

    assign mov_rn_hit = (opcode[7:3] == OP_MOV_RN_IMM[7:3]);

    always_comb begin
        op_class           = '0;
        op_class.needs_imm = (|imm_hit) | mov_rn_hit;
        op_class.needs_reg = |reg_hit;
        op_class.wb_to_rn  = mov_rn_hit;
        op_class.legal     = op_class.needs_imm | op_class.needs_reg;
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Decodes ALU-class 8051 opcodes, gathers operands, issues one ALU cycle and
// writes the result back to ACC or Rn; one instruction in flight at a time.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [7:0] instr_byte,
    output logic       instr_ready,
    input  logic [7:0] acc_in,
    output logic [2:0] rf_raddr,
    input  logic [7:0] rf_rdata,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    output logic [7:0] alu_opcode,
    output logic       alu_en,
    input  logic [8:0] alu_result,
    output logic       wb_en,
    output logic       wb_sel,
    output logic [2:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       busy,
    output logic       illegal
);

    seq_state_t state_reg;
    logic [7:0] opcode_reg;
    logic [7:0] operand_reg;
    logic [7:0] op1_hold_reg;
    logic [2:0] rn_reg;
    logic       wb_to_rn_reg;
    logic       wb_en_reg;
    logic       wb_sel_reg;
    logic [2:0] wb_addr_reg;
    logic       illegal_reg;
    op_class_t  byte_class;
    logic       unused_alu_carry;

    alu_opcode_decoder u_decoder (
        .opcode   (instr_byte),
        .op_class (byte_class)
    );

    // Carry out of the ALU is consumed elsewhere; only the 8-bit result is written back.
    assign unused_alu_carry = alu_result[8];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            opcode_reg   <= NOP_OPCODE;
            operand_reg  <= 8'h00;
            op1_hold_reg <= 8'h00;
            rn_reg       <= 3'd0;
            wb_to_rn_reg <= 1'b0;
            wb_en_reg    <= 1'b0;
            wb_sel_reg   <= 1'b0;
            wb_addr_reg  <= 3'd0;
            illegal_reg  <= 1'b0;
        end else begin
            illegal_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (instr_valid) begin
                        if (byte_class.legal) begin
                            opcode_reg   <= instr_byte;
                            rn_reg       <= instr_byte[2:0];
                            wb_to_rn_reg <= byte_class.wb_to_rn;
                            state_reg    <= byte_class.needs_imm ? ST_FETCH_IMM : ST_READ_REG;
                        end else begin
                            illegal_reg <= 1'b1;
                        end
                    end
                end
                ST_FETCH_IMM: begin
                    if (instr_valid) begin
                        operand_reg <= instr_byte;
                        state_reg   <= ST_ISSUE;
                    end
                end
                ST_READ_REG: begin
                    operand_reg <= rf_rdata;
                    state_reg   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    op1_hold_reg <= acc_in;
                    wb_en_reg    <= 1'b1;
                    wb_sel_reg   <= wb_to_rn_reg;
                    wb_addr_reg  <= wb_to_rn_reg ? rn_reg : 3'd0;
                    state_reg    <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    wb_en_reg   <= 1'b0;
                    wb_sel_reg  <= 1'b0;
                    wb_addr_reg <= 3'd0;
                    state_reg   <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready  = (state_reg == ST_IDLE) || (state_reg == ST_FETCH_IMM);
    assign busy         = (state_reg != ST_IDLE);
    assign illegal      = illegal_reg;
    // The register bank samples the address at the opcode handshake edge.
    assign rf_raddr     = (state_reg == ST_IDLE) ? instr_byte[2:0] : rn_reg;
    assign alu_en       = (state_reg == ST_ISSUE);
    assign alu_opcode   = (state_reg == ST_ISSUE) ? opcode_reg : NOP_OPCODE;
    assign alu_operand1 = (state_reg == ST_ISSUE) ? acc_in : op1_hold_reg;
    assign alu_operand2 = operand_reg;
    assign wb_en        = wb_en_reg;
    assign wb_sel       = wb_sel_reg;
    assign wb_addr      = wb_addr_reg;
    assign wb_data      = wb_en_reg ? alu_result[7:0] : 8'h00;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural ALU, register bank and ACC.
module tb_alu_operand_sequencer;

    logic       clock;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr_byte;
    logic       instr_ready;
    logic [7:0] acc;
    logic [2:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic [7:0] alu_operand1;
    logic [7:0] alu_operand2;
    logic [7:0] alu_opcode;
    logic       alu_en;
    logic [8:0] alu_result;
    logic       wb_en;
    logic       wb_sel;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       busy;
    logic       illegal;

    logic       acc_load;
    logic [7:0] acc_load_val;
    logic       rf_load;
    logic [2:0] rf_load_idx;
    logic [7:0] rf_load_val;
    logic [7:0] rf [8];

    int checks;
    int errors;

    alu_operand_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_byte   (instr_byte),
        .instr_ready  (instr_ready),
        .acc_in       (acc),
        .rf_raddr     (rf_raddr),
        .rf_rdata     (rf_rdata),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_opcode   (alu_opcode),
        .alu_en       (alu_en),
        .alu_result   (alu_result),
        .wb_en        (wb_en),
        .wb_sel       (wb_sel),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .busy         (busy),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] alu_model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        casez (op)
            8'h24, 8'b00101???: r = {1'b0, a} + {1'b0, b};
            8'h94, 8'b10011???: r = {1'b0, a} - {1'b0, b};
            8'h54, 8'b01011???: r = {1'b0, a & b};
            8'h44, 8'b01001???: r = {1'b0, a | b};
            8'h64, 8'b01101???: r = {1'b0, a ^ b};
            default:            r = {1'b0, b};
        endcase
        return r;
    endfunction

    // ALU registers its result on the ISSUE edge.
    initial alu_result = 9'h000;
    always @(posedge clock) begin
        if (alu_en) alu_result <= alu_model(alu_opcode, alu_operand1, alu_operand2);
    end

    always @(posedge clock) begin
        rf_rdata <= rf[rf_raddr];
        if (rf_load) rf[rf_load_idx] <= rf_load_val;
        else if (wb_en && wb_sel) rf[wb_addr] <= wb_data;
    end

    always @(posedge clock) begin
        if (acc_load) acc <= acc_load_val;
        else if (wb_en && !wb_sel) acc <= wb_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("check %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_acc(input logic [7:0] v);
        acc_load     = 1'b1;
        acc_load_val = v;
        tick();
        acc_load     = 1'b0;
    endtask

    task automatic set_rf(input logic [2:0] idx, input logic [7:0] v);
        rf_load     = 1'b1;
        rf_load_idx = idx;
        rf_load_val = v;
        tick();
        rf_load     = 1'b0;
    endtask

    logic [7:0] stream [4];
    int         idx;
    int         wb_count;
    int         wb_cycle [2];
    logic       hs;

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        instr_valid  = 1'b0;
        instr_byte   = 8'h00;
        acc_load     = 1'b0;
        acc_load_val = 8'h00;
        rf_load      = 1'b0;
        rf_load_idx  = 3'd0;
        rf_load_val  = 8'h00;
        #1;
        check_eq("rst_instr_ready", 32'(instr_ready), 'h1);
        check_eq("rst_alu_opcode", 32'(alu_opcode), 'h00);
        check_eq("rst_busy", 32'(busy), 'h0);
        check_eq("rst_alu_en", 32'(alu_en), 'h0);
        check_eq("rst_wb_en", 32'(wb_en), 'h0);
        tick();
        tick();
        reset = 1'b1;

        // ADD A,#15h with ACC = 3Ah
        set_acc(8'h3A);
        $display("txn ADD A,#15h");
        instr_valid = 1'b1;
        instr_byte  = 8'h24;
        tick();
        check_eq("add_fetch_busy", 32'(busy), 'h1);
        check_eq("add_fetch_ready", 32'(instr_ready), 'h1);
        instr_byte = 8'h15;
        tick();
        instr_valid = 1'b0;
        check_eq("add_issue_en", 32'(alu_en), 'h1);
        check_eq("add_issue_opcode", 32'(alu_opcode), 'h24);
        check_eq("add_issue_op1", 32'(alu_operand1), 'h3A);
        check_eq("add_issue_op2", 32'(alu_operand2), 'h15);
        tick();
        check_eq("add_wb_en", 32'(wb_en), 'h1);
        check_eq("add_wb_sel", 32'(wb_sel), 'h0);
        check_eq("add_wb_data", 32'(wb_data), 'h4F);
        check_eq("add_wb_nop", 32'(alu_opcode), 'h00);
        tick();
        check_eq("add_idle_wb_en", 32'(wb_en), 'h0);
        check_eq("add_idle_busy", 32'(busy), 'h0);

        // ORL A,R5 with R5 = F0h, ACC = 0Fh
        set_rf(3'd5, 8'hF0);
        set_acc(8'h0F);
        $display("txn ORL A,R5");
        instr_valid = 1'b1;
        instr_byte  = 8'h4D;
        #1;
        check_eq("orl_raddr", 32'(rf_raddr), 'h5);
        tick();
        instr_valid = 1'b0;
        check_eq("orl_read_ready", 32'(instr_ready), 'h0);
        check_eq("orl_read_en", 32'(alu_en), 'h0);
        tick();
        check_eq("orl_issue_en", 32'(alu_en), 'h1);
        check_eq("orl_issue_op1", 32'(alu_operand1), 'h0F);
        check_eq("orl_issue_op2", 32'(alu_operand2), 'hF0);
        tick();
        check_eq("orl_wb_en", 32'(wb_en), 'h1);
        check_eq("orl_wb_sel", 32'(wb_sel), 'h0);
        check_eq("orl_wb_data", 32'(wb_data), 'hFF);
        tick();

        // MOV R2,#A5h
        $display("txn MOV R2,#A5h");
        instr_valid = 1'b1;
        instr_byte  = 8'h7A;
        tick();
        instr_byte = 8'hA5;
        tick();
        instr_valid = 1'b0;
        check_eq("movrn_issue_ready", 32'(instr_ready), 'h0);
        check_eq("movrn_issue_opcode", 32'(alu_opcode), 'h7A);
        tick();
        check_eq("movrn_wb_ready", 32'(instr_ready), 'h0);
        check_eq("movrn_wb_en", 32'(wb_en), 'h1);
        check_eq("movrn_wb_sel", 32'(wb_sel), 'h1);
        check_eq("movrn_wb_addr", 32'(wb_addr), 'h2);
        check_eq("movrn_wb_data", 32'(wb_data), 'hA5);
        tick();

        // SUBB A,#01h with the immediate starved for five cycles; ACC = FFh
        $display("txn SUBB A,#01h starved");
        instr_valid = 1'b1;
        instr_byte  = 8'h94;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("subb_wait_en", 32'(alu_en), 'h0);
            check_eq("subb_wait_ready", 32'(instr_ready), 'h1);
        end
        instr_valid = 1'b1;
        instr_byte  = 8'h01;
        tick();
        instr_valid = 1'b0;
        check_eq("subb_issue_en", 32'(alu_en), 'h1);
        check_eq("subb_issue_op1", 32'(alu_operand1), 'hFF);
        check_eq("subb_issue_op2", 32'(alu_operand2), 'h01);
        tick();
        check_eq("subb_wb_data", 32'(wb_data), 'hFE);
        tick();

        // Illegal byte in IDLE
        $display("txn illegal A0h");
        instr_valid = 1'b1;
        instr_byte  = 8'hA0;
        tick();
        instr_valid = 1'b0;
        check_eq("illegal_pulse", 32'(illegal), 'h1);
        check_eq("illegal_busy", 32'(busy), 'h0);
        check_eq("illegal_alu_en", 32'(alu_en), 'h0);
        tick();
        check_eq("illegal_clear", 32'(illegal), 'h0);

        // Reset during ISSUE of ANL A,#0Fh
        $display("txn ANL A,#0Fh aborted by reset");
        instr_valid = 1'b1;
        instr_byte  = 8'h54;
        tick();
        instr_byte = 8'h0F;
        tick();
        instr_valid = 1'b0;
        check_eq("anl_issue_en", 32'(alu_en), 'h1);
        reset = 1'b0;
        #1;
        check_eq("abort_alu_en", 32'(alu_en), 'h0);
        check_eq("abort_opcode", 32'(alu_opcode), 'h00);
        check_eq("abort_busy", 32'(busy), 'h0);
        check_eq("abort_ready", 32'(instr_ready), 'h1);
        tick();
        check_eq("abort_wb_en", 32'(wb_en), 'h0);
        reset = 1'b1;

        $display("txn MOV A,#33h after reset");
        instr_valid = 1'b1;
        instr_byte  = 8'h74;
        tick();
        instr_byte = 8'h33;
        tick();
        instr_valid = 1'b0;
        tick();
        check_eq("mova_wb_en", 32'(wb_en), 'h1);
        check_eq("mova_wb_sel", 32'(wb_sel), 'h0);
        check_eq("mova_wb_data", 32'(wb_data), 'h33);
        tick();

        // Back-to-back ADD A,#01h twice from ACC = 33h
        $display("txn back-to-back ADD A,#01h x2");
        stream[0] = 8'h24;
        stream[1] = 8'h01;
        stream[2] = 8'h24;
        stream[3] = 8'h01;
        idx       = 0;
        wb_count  = 0;
        for (int c = 0; c < 12; c++) begin
            instr_valid = (idx < 4);
            instr_byte  = (idx < 4) ? stream[idx] : 8'h00;
            #1;
            hs = instr_valid && instr_ready;
            if (wb_en) begin
                if (wb_count < 2) begin
                    wb_cycle[wb_count] = c;
                    check_eq("b2b_wb_data", 32'(wb_data), (wb_count == 0) ? 'h34 : 'h35);
                end
                wb_count++;
            end
            if (!alu_en) check_eq("b2b_nop_opcode", 32'(alu_opcode), 'h00);
            tick();
            if (hs) idx++;
        end
        instr_valid = 1'b0;
        check_eq("b2b_wb_count", 32'(wb_count), 'h2);
        if (wb_count >= 2)
            check_eq("b2b_wb_spacing", 32'(wb_cycle[1] - wb_cycle[0]), 'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
